// File: rtl/wb_register_file.sv
// Architectural RV32I register file x0..x31: two combinational operand reads with
// optional WB->ID bypass, a non-bypassed debug read, and a committed-write counter.
module wb_register_file #(
    parameter int XLEN   = 32,
    parameter int BYPASS = 1,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             regwrite_WB,
    input  logic [4:0]       rd_WB,
    input  logic [XLEN-1:0]  rd_data_WB,
    input  logic [4:0]       rs1_ID,
    input  logic [4:0]       rs2_ID,
    output logic [XLEN-1:0]  rs1_data_ID,
    output logic [XLEN-1:0]  rs2_data_ID,
    input  logic [4:0]       dbg_addr,
    output logic [XLEN-1:0]  dbg_data,
    output logic [CNT_W-1:0] wb_count
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // x0 has no storage; it is hardwired to zero in the read paths.
    logic [XLEN-1:0]  regs [1:31];
    logic [CNT_W-1:0] count;
    logic             commit;

    assign commit = regwrite_WB && (rd_WB != 5'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 1; i < 32; i++) begin
                regs[i] <= '0;
            end
            count <= '0;
        end else if (commit) begin
            regs[rd_WB] <= rd_data_WB;
            count       <= count + CNT_ONE;
        end
    end

    function automatic logic [XLEN-1:0] stored_value(input logic [4:0] idx);
        if (idx == 5'd0) begin
            return '0;
        end
        return regs[idx];
    endfunction

    // The bypass compare requires a nonzero index, so x0 is never forwarded.
    function automatic logic [XLEN-1:0] operand_value(input logic [4:0] idx);
        if (idx == 5'd0) begin
            return '0;
        end
        if ((BYPASS != 0) && regwrite_WB && (rd_WB == idx)) begin
            return rd_data_WB;
        end
        return regs[idx];
    endfunction

    always_comb begin
        rs1_data_ID = operand_value(rs1_ID);
        rs2_data_ID = operand_value(rs2_ID);
        dbg_data    = stored_value(dbg_addr);
    end

    assign wb_count = count;

endmodule

// File: tb/tb_wb_register_file.sv
// Bench for wb_register_file: a bypassing 32-bit-counter build and a non-bypassing
// 4-bit-counter build driven side by side from shared stimulus.
module tb_wb_register_file;

    logic        clk;
    logic        reset;
    logic        regwrite_WB;
    logic [4:0]  rd_WB;
    logic [31:0] rd_data_WB;
    logic [4:0]  rs1_ID;
    logic [4:0]  rs2_ID;
    logic [4:0]  dbg_addr;

    logic [31:0] rs1_a, rs2_a, dbg_a, cnt_a;
    logic [31:0] rs1_b, rs2_b, dbg_b;
    logic [3:0]  cnt_b;

    int errors = 0;
    int checks = 0;

    wb_register_file #(.XLEN(32), .BYPASS(1), .CNT_W(32)) dut_a (
        .clk(clk), .reset(reset), .regwrite_WB(regwrite_WB), .rd_WB(rd_WB),
        .rd_data_WB(rd_data_WB), .rs1_ID(rs1_ID), .rs2_ID(rs2_ID),
        .rs1_data_ID(rs1_a), .rs2_data_ID(rs2_a), .dbg_addr(dbg_addr),
        .dbg_data(dbg_a), .wb_count(cnt_a)
    );

    wb_register_file #(.XLEN(32), .BYPASS(0), .CNT_W(4)) dut_b (
        .clk(clk), .reset(reset), .regwrite_WB(regwrite_WB), .rd_WB(rd_WB),
        .rd_data_WB(rd_data_WB), .rs1_ID(rs1_ID), .rs2_ID(rs2_ID),
        .rs1_data_ID(rs1_b), .rs2_data_ID(rs2_b), .dbg_addr(dbg_addr),
        .dbg_data(dbg_b), .wb_count(cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  dbg;
        logic [31:0] e_rs1;
        logic [31:0] e_rs2;
        logic [31:0] e_rs1_nb;
        logic [31:0] e_rs2_nb;
        logic [31:0] e_dbg;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t vecs [8];

    logic [31:0] m_regs [32];
    logic [31:0] m_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [4:0] rd, input logic [31:0] data,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] dbg);
        regwrite_WB = we;
        rd_WB       = rd;
        rd_data_WB  = data;
        rs1_ID      = rs1;
        rs2_ID      = rs2;
        dbg_addr    = dbg;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] idx, input bit byp);
        if (idx == 0) return 32'h0;
        if (byp && regwrite_WB && rd_WB == idx) return rd_data_WB;
        return m_regs[idx];
    endfunction

    initial begin
        vecs[0] = '{1'b1, 5'd7, 32'h12345678, 5'd7, 5'd7, 5'd7,
                    32'h12345678, 32'h12345678, 32'h0, 32'h0, 32'h0, 32'd0};
        vecs[1] = '{1'b0, 5'd7, 32'h0, 5'd7, 5'd0, 5'd7,
                    32'h12345678, 32'h0, 32'h12345678, 32'h0, 32'h12345678, 32'd1};
        vecs[2] = '{1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd7, 5'd0,
                    32'h0, 32'h12345678, 32'h0, 32'h12345678, 32'h0, 32'd1};
        vecs[3] = '{1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0,
                    32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'd1};
        vecs[4] = '{1'b1, 5'd3, 32'h11, 5'd0, 5'd0, 5'd3,
                    32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'd1};
        vecs[5] = '{1'b1, 5'd3, 32'h22, 5'd3, 5'd3, 5'd3,
                    32'h22, 32'h22, 32'h11, 32'h11, 32'h11, 32'd2};
        vecs[6] = '{1'b0, 5'd9, 32'hAA, 5'd3, 5'd9, 5'd3,
                    32'h22, 32'h0, 32'h22, 32'h0, 32'h22, 32'd3};
        vecs[7] = '{1'b0, 5'd0, 32'h0, 5'd9, 5'd3, 5'd9,
                    32'h0, 32'h22, 32'h0, 32'h22, 32'h0, 32'd3};

        reset = 1'b1;
        drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);
        #1;
        for (int i = 1; i < 32; i += 10) begin
            dbg_addr = i[4:0];
            #1;
            check($sformatf("reset_dbg_x%0d", i), dbg_a, 32'h0);
        end
        check("reset_cnt_a", cnt_a, 32'h0);
        tick();
        reset = 1'b0;

        // Table-driven directed vectors, checked just before each commit edge.
        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].we, vecs[i].rd, vecs[i].data, vecs[i].rs1, vecs[i].rs2, vecs[i].dbg);
            #1;
            check($sformatf("v%0d_rs1_a", i), rs1_a, vecs[i].e_rs1);
            check($sformatf("v%0d_rs2_a", i), rs2_a, vecs[i].e_rs2);
            check($sformatf("v%0d_rs1_b", i), rs1_b, vecs[i].e_rs1_nb);
            check($sformatf("v%0d_rs2_b", i), rs2_b, vecs[i].e_rs2_nb);
            check($sformatf("v%0d_dbg_a", i), dbg_a, vecs[i].e_dbg);
            check($sformatf("v%0d_dbg_b", i), dbg_b, vecs[i].e_dbg);
            check($sformatf("v%0d_cnt_a", i), cnt_a, vecs[i].e_cnt);
            check($sformatf("v%0d_cnt_b", i), {28'h0, cnt_b}, vecs[i].e_cnt & 32'hF);
            tick();
        end

        // Asynchronous reset between edges clears state before the next edge.
        drive(1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd7, 5'd5);
        tick();
        drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd7, 5'd5);
        #1;
        check("pre_reset_x5", rs1_a, 32'hDEADBEEF);
        check("pre_reset_cnt", cnt_a, 32'd4);
        #1;
        reset = 1'b1;
        #1;
        check("async_rst_rs1_a", rs1_a, 32'h0);
        check("async_rst_rs2_a", rs2_a, 32'h0);
        check("async_rst_rs1_b", rs1_b, 32'h0);
        check("async_rst_cnt_a", cnt_a, 32'h0);
        check("async_rst_cnt_b", {28'h0, cnt_b}, 32'h0);

        // A write presented while reset is held is lost.
        drive(1'b1, 5'd5, 32'hCAFEF00D, 5'd0, 5'd0, 5'd5);
        tick();
        drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd5);
        reset = 1'b0;
        #1;
        check("write_in_reset_x5", dbg_a, 32'h0);
        check("write_in_reset_cnt", cnt_a, 32'h0);

        // Reset released before the edge: the write on that edge commits.
        reset = 1'b1;
        drive(1'b1, 5'd6, 32'h66, 5'd0, 5'd0, 5'd6);
        #2;
        reset = 1'b0;
        tick();
        drive(1'b0, 5'd0, 32'h0, 5'd6, 5'd0, 5'd6);
        #1;
        check("rst_release_x6_dbg", dbg_a, 32'h66);
        check("rst_release_x6_rs1_b", rs1_b, 32'h66);
        check("rst_release_cnt", cnt_a, 32'd1);

        // Counter wrap on the 4-bit build: bring it to 14, then 16 more writes.
        for (int i = 0; i < 13; i++) begin
            drive(1'b1, 5'((i % 31) + 1), 32'(i), 5'd0, 5'd0, 5'd0);
            tick();
        end
        drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);
        #1;
        check("wrap_start_b", {28'h0, cnt_b}, 32'd14);
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 5'((i % 31) + 1), 32'(i + 100), 5'd0, 5'd0, 5'd0);
            tick();
            if (i == 0) check("wrap_at_15_b", {28'h0, cnt_b}, 32'd15);
            if (i == 1) check("wrap_to_0_b", {28'h0, cnt_b}, 32'd0);
        end
        drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);
        #1;
        check("wrap_end_b", {28'h0, cnt_b}, 32'd14);
        check("wrap_end_a", cnt_a, 32'd30);

        // Randomized traffic against a plain array-and-counter reference.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        m_cnt = 32'h0;
        for (int n = 0; n < 400; n++) begin
            logic [4:0] rd;
            rd = ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom_range(31));
            drive(1'($urandom_range(1)), rd, $urandom(),
                  ($urandom_range(2) == 0) ? rd : 5'($urandom_range(31)),
                  ($urandom_range(2) == 0) ? rd : 5'($urandom_range(31)),
                  ($urandom_range(3) == 0) ? rd : 5'($urandom_range(31)));
            #1;
            check($sformatf("rnd%0d_rs1_a", n), rs1_a, model_read(rs1_ID, 1'b1));
            check($sformatf("rnd%0d_rs2_a", n), rs2_a, model_read(rs2_ID, 1'b1));
            check($sformatf("rnd%0d_rs1_b", n), rs1_b, model_read(rs1_ID, 1'b0));
            check($sformatf("rnd%0d_rs2_b", n), rs2_b, model_read(rs2_ID, 1'b0));
            check($sformatf("rnd%0d_dbg_a", n), dbg_a, model_read(dbg_addr, 1'b0));
            check($sformatf("rnd%0d_dbg_b", n), dbg_b, model_read(dbg_addr, 1'b0));
            check($sformatf("rnd%0d_cnt_a", n), cnt_a, m_cnt);
            check($sformatf("rnd%0d_cnt_b", n), {28'h0, cnt_b}, m_cnt % 16);
            if (regwrite_WB && rd_WB != 0) begin
                m_regs[rd_WB] = rd_data_WB;
                m_cnt = m_cnt + 1;
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
